// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C arbiter: FSM encoding, rw polarity, address width.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic I2C_RW_READ  = 1'b0;
  localparam logic I2C_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic [2*N_REQ-1:0] req2;
  int unsigned        p;

  assign req2 = {req_i, req_i};

  // Scanning the doubled vector from ptr covers the wrap-around without a modulo.
  always_comb begin
    p       = 32'(ptr_i);
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      if (!valid_o && (i >= p) && (i < p + N_REQ) && req2[i]) begin
        valid_o = 1'b1;
        idx_o   = (i >= N_REQ) ? PTR_W'(i - N_REQ) : PTR_W'(i);
      end
    end
    gnt_o = valid_o ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between N_REQ requesters.
// Optional watchdog enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [I2C_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]              req_rw,
  input  logic [I2C_DATA_W*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              done,
  output logic [I2C_DATA_W-1:0]         rdata,
  output logic                          nack,
  output logic                          timeout,
  output logic [2:0]                    state,
  output logic                          m_start,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic                          m_rw,
  output logic [I2C_DATA_W-1:0]         m_wdata,
  input  logic                          m_busy,
  input  logic                          m_done,
  input  logic [I2C_DATA_W-1:0]         m_rdata,
  input  logic                          m_nack
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_e                state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d, idx_q, idx_d;
  logic [N_REQ-1:0]          sel_q, sel_d;
  logic [I2C_ADDR_W-1:0]     addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic [I2C_DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic                      nack_q, nack_d;

  logic [N_REQ-1:0]          pick_oh;
  logic [PTR_W-1:0]          pick_idx;
  logic                      pick_vld;
  logic                      active, finish;
  logic                      tmo_hit;

  logic [I2C_ADDR_W-1:0]     addr_arr  [N_REQ];
  logic [I2C_DATA_W-1:0]     wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[I2C_ADDR_W*g +: I2C_ADDR_W];
    assign wdata_arr[g] = req_wdata[I2C_DATA_W*g +: I2C_DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign active = (state_q == ST_START) || (state_q == ST_WAIT);
  assign finish = active && m_done;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign tmo_hit = active && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (finish) begin
      timeout_d = 1'b0;
    end else if (tmo_hit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // m_done takes priority over the watchdog when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_START;
          idx_d   = pick_idx;
          sel_d   = pick_oh;
          addr_d  = addr_arr[pick_idx];
          rw_d    = req_rw[pick_idx];
          wdata_d = wdata_arr[pick_idx];
        end
      end
      ST_START, ST_WAIT: begin
        if (m_done) begin
          state_d = ST_DONE;
          nack_d  = m_nack;
          if (rw_q == I2C_RW_READ) begin
            rdata_d = m_rdata;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          nack_d  = 1'b1;
        end else if ((state_q == ST_START) && m_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    gnt     = '0;
    done    = '0;
    m_start = 1'b0;
    case (state_q)
      ST_START: begin
        gnt     = sel_q;
        m_start = 1'b1;
      end
      ST_WAIT: gnt  = sel_q;
      ST_DONE: done = sel_q;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign m_addr  = addr_q;
  assign m_rw    = rw_q;
  assign m_wdata = wdata_q;
  assign rdata   = rdata_q;
  assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed vector table, corner sequences, random traffic.
module tb_i2c_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rdata;
  logic           nack, timeout;
  logic [2:0]     state;
  logic           m_start;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_wdata;
  logic           m_busy, m_done;
  logic [7:0]     m_rdata;
  logic           m_nack;

  always #5 clk = ~clk;

  i2c_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .nack      (nack),
    .timeout   (timeout),
    .state     (state),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rdata   (m_rdata),
    .m_nack    (m_nack)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned mdl_ptr   = 0;
  logic [7:0]  mdl_rdata = 8'h00;

  typedef struct {
    logic [N-1:0] r;
    logic [6:0]   ab;
    logic [7:0]   wb;
    logic         rwb;
    int unsigned  busy;
    logic [7:0]   mrd;
    logic         mnk;
    bit           hold;
    int unsigned  exp_idx;
    logic [7:0]   exp_rd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: first requester at or after the pointer, counting modulo N.
  function automatic int unsigned model_pick(input logic [N-1:0] r, input int unsigned p);
    for (int unsigned i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return N;
  endfunction

  // Requester k gets addr ab^k, wdata wb^(k<<4), rw rwb^k[0], so a wrong index is visible.
  task automatic set_cmds(input logic [N-1:0] r, input logic [6:0] ab, input logic [7:0] wb,
                          input logic rwb);
    for (int unsigned k = 0; k < N; k++) begin
      req_addr[7*k +: 7]  = ab ^ 7'(k);
      req_wdata[8*k +: 8] = wb ^ 8'(k << 4);
      req_rw[k]           = rwb ^ k[0];
    end
    req = r;
  endtask

  task automatic wait_gnt(output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 8);
  endtask

  task automatic run_txn(input logic [N-1:0] r, input logic [6:0] ab, input logic [7:0] wb,
                         input logic rwb, input int unsigned busy, input logic [7:0] mrd,
                         input logic mnk, input bit hold, input bit drop,
                         input int unsigned exp_idx, input logic [7:0] exp_rd);
    int unsigned  n;
    logic [N-1:0] oh;
    oh = N'(1) << exp_idx;
    set_cmds(r, ab, wb, rwb);
    wait_gnt(n);
    chk("gnt_latency", 64'(n), 64'd1);
    chk("gnt", 64'(gnt), 64'(oh));
    chk("m_start", 64'(m_start), 64'd1);
    chk("state_start", 64'(state), 64'd1);
    chk("m_addr", 64'(m_addr), 64'(7'(ab ^ 7'(exp_idx))));
    chk("m_wdata", 64'(m_wdata), 64'(8'(wb ^ 8'(exp_idx << 4))));
    chk("m_rw", 64'(m_rw), 64'(rwb ^ exp_idx[0]));
    for (int unsigned b = 0; b < busy; b++) begin
      m_busy = 1'b1;
      if (drop) req = '0;
      @(negedge clk);
      if (b == 0) begin
        chk("gnt_hold", 64'(gnt), 64'(oh));
        chk("m_start_drop", 64'(m_start), 64'd0);
      end
    end
    m_busy  = 1'b0;
    m_done  = 1'b1;
    m_rdata = mrd;
    m_nack  = mnk;
    @(negedge clk);
    m_done  = 1'b0;
    m_rdata = 8'($urandom);
    m_nack  = 1'($urandom);
    chk("done", 64'(done), 64'(oh));
    chk("gnt_off", 64'(gnt), 64'd0);
    chk("rdata", 64'(rdata), 64'(exp_rd));
    chk("nack", 64'(nack), 64'(mnk));
    chk("timeout_clr", 64'(timeout), 64'd0);
    chk("state_done", 64'(state), 64'd3);
    if (!hold) req = '0;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_gap", 64'(gnt), 64'd0);
    chk("state_idle", 64'(state), 64'd0);
    mdl_ptr   = (exp_idx + 1) % N;
    mdl_rdata = exp_rd;
  endtask

  task automatic reset_in_wait();
    int unsigned n;
    if (state == 3'd0) begin
      set_cmds(4'b0001, 7'h22, 8'h33, 1'b0);
      wait_gnt(n);
      m_busy = 1'b1;
      @(negedge clk);
    end
    chk("pre_reset_wait", 64'(state), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_m_start", 64'(m_start), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_data", 64'({rdata, nack, timeout, m_addr, m_rw, m_wdata}), 64'd0);
    m_busy = 1'b0;
    req    = '0;
    @(negedge clk);
    rst       = 1'b1;
    mdl_ptr   = 0;
    mdl_rdata = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1, "tb watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic [6:0]   ab;
    logic [7:0]   wb, mrd, erd;
    logic         rwb, mnk, erw;
    int unsigned  busy, ei, n;
    bit           hold;

    rst = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
    #12;
    chk("reset_ctl", 64'({gnt, done, state, m_start}), 64'd0);
    chk("reset_data", 64'({rdata, nack, timeout, m_addr, m_rw, m_wdata}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    //         r        ab     wb     rwb  busy mrd    mnk  hold idx rd
    tbl[0] = '{4'b1111, 7'h10, 8'h01, 1'b1, 1, 8'h11, 1'b0, 1'b1, 0, 8'h00};
    tbl[1] = '{4'b1111, 7'h10, 8'h01, 1'b1, 2, 8'h22, 1'b0, 1'b1, 1, 8'h22};
    tbl[2] = '{4'b1111, 7'h10, 8'h01, 1'b1, 1, 8'h33, 1'b1, 1'b1, 2, 8'h22};
    tbl[3] = '{4'b1111, 7'h10, 8'h01, 1'b1, 0, 8'h44, 1'b0, 1'b1, 3, 8'h44};
    tbl[4] = '{4'b1111, 7'h10, 8'h01, 1'b1, 1, 8'h55, 1'b0, 1'b0, 0, 8'h44};
    tbl[5] = '{4'b0100, 7'h2A, 8'h10, 1'b0, 2, 8'h3C, 1'b1, 1'b0, 2, 8'h3C};
    tbl[6] = '{4'b0001, 7'h50, 8'hA5, 1'b1, 3, 8'h99, 1'b0, 1'b0, 0, 8'h3C};
    tbl[7] = '{4'b1010, 7'h61, 8'h5A, 1'b1, 1, 8'h6E, 1'b0, 1'b0, 1, 8'h6E};
    tbl[8] = '{4'b1010, 7'h61, 8'h5A, 1'b1, 2, 8'h07, 1'b1, 1'b0, 3, 8'h07};
    tbl[9] = '{4'b0110, 7'h0F, 8'hC3, 1'b0, 1, 8'hEE, 1'b0, 1'b0, 1, 8'h07};

    foreach (tbl[i]) begin
      run_txn(tbl[i].r, tbl[i].ab, tbl[i].wb, tbl[i].rwb, tbl[i].busy, tbl[i].mrd,
              tbl[i].mnk, tbl[i].hold, 1'b0, tbl[i].exp_idx, tbl[i].exp_rd);
    end

    // Requester 1 lets go of req while the master is busy; the transaction still completes.
    run_txn(4'b0010, 7'h3E, 8'h81, 1'b1, 3, 8'h5A, 1'b0, 1'b0, 1'b1, 1, 8'h5A);
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_regrant", 64'({gnt, state}), 64'd0);
    end

    // Stray m_done while idle must not disturb the held result.
    m_done = 1'b1; m_rdata = 8'hFF; m_nack = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    @(negedge clk);
    chk("idle_mdone", 64'({rdata, nack, done, state}), 64'({8'h5A, 1'b0, 4'b0000, 3'd0}));

    for (int t = 0; t < 40; t++) begin
      r    = N'($urandom_range(1, (1 << N) - 1));
      ab   = 7'($urandom);
      wb   = 8'($urandom);
      rwb  = 1'($urandom);
      busy = $urandom_range(0, 4);
      mrd  = 8'($urandom);
      mnk  = 1'($urandom);
      hold = bit'($urandom_range(0, 1));
      ei   = model_pick(r, mdl_ptr);
      erw  = rwb ^ ei[0];
      erd  = (erw == 1'b0) ? mrd : mdl_rdata;
      run_txn(r, ab, wb, rwb, busy, mrd, mnk, hold, 1'b0, ei, erd);
    end
    req = '0;

    // Master that never reports completion.
    set_cmds(4'b0100, 7'h44, 8'h12, 1'b0);
    wait_gnt(n);
    chk("tmo_gnt", 64'(gnt), 64'(4'b0100));
    m_busy = 1'b1;
    n = 0;
    while (done == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifdef I2C_ARB_TIMEOUT_EN
    chk("tmo_cycles", 64'(n), 64'(TMO));
    chk("tmo_done", 64'(done), 64'(4'b0100));
    chk("tmo_flags", 64'({timeout, nack}), 64'(2'b11));
    chk("tmo_rdata", 64'(rdata), 64'(mdl_rdata));
    chk("tmo_m_start", 64'(m_start), 64'd0);
    m_busy = 1'b0;
    req    = '0;
    @(negedge clk);
    mdl_ptr = 3;
`else
    chk("no_tmo_wait", 64'(n), 64'd40);
    chk("no_tmo_state", 64'(state), 64'd2);
    chk("no_tmo_flag", 64'(timeout), 64'd0);
    chk("no_tmo_gnt", 64'(gnt), 64'(4'b0100));
`endif

    reset_in_wait();
    @(negedge clk);
    run_txn(4'b1111, 7'h7F, 8'hFE, 1'b0, 1, 8'hB4, 1'b0, 1'b0, 1'b0, 0, 8'hB4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
